// File: rtl/id_pkg.sv
// id_pkg: opcodes, write-back selectors and the ID/EX control payload shared by the decode stage
package id_pkg;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_FENCE  = 7'h0F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;
    localparam logic [2:0] ADDI = 3'd0;
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;
    // WIDTH-dependent data words live beside this struct in the top, since packages cannot be parametrised
    typedef struct packed {
        logic [6:0] op;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic       jump_branch_sel;
        logic       mem_wr_en;
        logic       reg_wr_en;
        logic [1:0] reg_wr_ctrl;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       valid;
        logic       illegal;
    } idex_t;
    localparam idex_t BUBBLE = '{op: OP_IMM, funct3: ADDI, default: '0};
    function automatic logic reg_ok(input logic [4:0] r, input int n);
        return 32'(r) < n;
    endfunction
endpackage

// File: rtl/control_unit.sv
// control_unit: opcode to operand-select, enable, register-usage and legality decode
module control_unit
    import id_pkg::*;
(
    input  logic [6:0] op,
    output logic       in1_pc,
    output logic       in2_imm,
    output logic       jump_branch_sel,
    output logic       mem_wr_en,
    output logic       reg_wr_en,
    output logic [1:0] reg_wr_ctrl,
    output logic       rs1_used,
    output logic       rs2_used,
    output logic       legal,
    output logic [2:0] imm_sel
);
    always_comb begin
        legal = op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                           OP_STORE, OP_IMM, OP_OP, OP_FENCE, OP_SYSTEM};
        in1_pc = op == OP_AUIPC || op == OP_JAL;
        in2_imm = !(op == OP_OP || op == OP_BRANCH);
        jump_branch_sel = op inside {OP_JAL, OP_JALR, OP_BRANCH};
        mem_wr_en = op == OP_STORE;
        reg_wr_en = op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_OP};
        reg_wr_ctrl = op == OP_LOAD ? WB_MEM : (op == OP_JAL || op == OP_JALR) ? WB_PC4 : WB_ALU;
        rs1_used = !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
        rs2_used = op inside {OP_OP, OP_STORE, OP_BRANCH};
        imm_sel = op == OP_STORE ? IMM_S : op == OP_BRANCH ? IMM_B :
                  (op == OP_LUI || op == OP_AUIPC) ? IMM_U : op == OP_JAL ? IMM_J : IMM_I;
    end
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: load-use detection and front-end stall request
module hazard_unit
    import id_pkg::*;
(
    input  logic       reset,
    input  logic       flush,
    input  logic       stall_EX,
    input  logic       valid_IFID,
    input  logic       rs1_used,
    input  logic       rs2_used,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       valid_IDEX,
    input  logic       reg_wr_en_IDEX,
    input  logic [1:0] reg_wr_ctrl_IDEX,
    input  logic [4:0] rd_IDEX,
    output logic       lu,
    output logic       stall_ID
);
    always_comb begin
        lu = valid_IFID && valid_IDEX && reg_wr_en_IDEX && reg_wr_ctrl_IDEX == WB_MEM &&
             rd_IDEX != 5'd0 && ((rs1_used && rs1 == rd_IDEX) || (rs2_used && rs2 == rd_IDEX));
        stall_ID = !reset && !flush && (stall_EX || lu);
    end
endmodule

// File: rtl/inst_splitter.sv
// inst_splitter: instruction field extraction and sign-extended immediate generation
module inst_splitter
    import id_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [31:0]      instruction,
    input  logic [2:0]       imm_sel,
    output logic [6:0]       op,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [2:0]       funct3,
    output logic [6:0]       funct7,
    output logic [WIDTH-1:0] immediate
);
    logic [31:0] imm32;
    always_comb begin
        op = instruction[6:0];
        rd = instruction[11:7];
        funct3 = instruction[14:12];
        rs1 = instruction[19:15];
        rs2 = instruction[24:20];
        funct7 = instruction[31:25];
        imm32 = imm_sel == IMM_S ? {{20{instruction[31]}}, instruction[31:25], instruction[11:7]} :
                imm_sel == IMM_B ? {{20{instruction[31]}}, instruction[7], instruction[30:25],
                                    instruction[11:8], 1'b0} :
                imm_sel == IMM_U ? {instruction[31:12], 12'b0} :
                imm_sel == IMM_J ? {{12{instruction[31]}}, instruction[19:12], instruction[20],
                                    instruction[30:21], 1'b0} :
                {{20{instruction[31]}}, instruction[31:20]};
        immediate = WIDTH'($signed(imm32));
    end
endmodule

// File: rtl/register_file.sv
// register_file: REG_COUNT x WIDTH registers, combinational reads, optional WB-to-ID bypass
module register_file
    import id_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int REG_COUNT = 32,
    parameter int BYPASS_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [4:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    output logic [WIDTH-1:0] rs1_data,
    output logic [WIDTH-1:0] rs2_data
);
    localparam int RA = $clog2(REG_COUNT);
    logic [WIDTH-1:0] regs [REG_COUNT];
    logic byp1, byp2;
    always_comb begin
        byp1 = BYPASS_EN != 0 && wr_en && wr_addr == rs1;
        byp2 = BYPASS_EN != 0 && wr_en && wr_addr == rs2;
        rs1_data = rs1 == 5'd0 || !reg_ok(rs1, REG_COUNT) ? '0 : byp1 ? wr_data : regs[rs1[RA-1:0]];
        rs2_data = rs2 == 5'd0 || !reg_ok(rs2, REG_COUNT) ? '0 : byp2 ? wr_data : regs[rs2[RA-1:0]];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < REG_COUNT; k++) regs[k] <= '0;
        end else if (wr_en && wr_addr != 5'd0 && reg_ok(wr_addr, REG_COUNT)) begin
            regs[wr_addr[RA-1:0]] <= wr_data;
        end
    end
endmodule

// File: rtl/id_stage_hazard.sv
// id_stage_hazard: decode stage with ID/EX register, load-use interlock, EX-stall hold and WB bypass
module id_stage_hazard
    import id_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int REG_COUNT = 32,
    parameter int BYPASS_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             stall_EX,
    input  logic [31:0]      instruction_IFID,
    input  logic [WIDTH-1:0] pc_IFID,
    input  logic [WIDTH-1:0] pc_4_IFID,
    input  logic             valid_IFID,
    input  logic [WIDTH-1:0] reg_wr_data_WBID,
    input  logic [4:0]       rd_WBID,
    input  logic             reg_wr_en_WBID,
    output logic             stall_ID,
    output logic [6:0]       op_IDEX,
    output logic [2:0]       funct3_IDEX,
    output logic [6:0]       funct7_IDEX,
    output logic [WIDTH-1:0] in1_IDEX,
    output logic [WIDTH-1:0] in2_IDEX,
    output logic [WIDTH-1:0] immediate_IDEX,
    output logic [WIDTH-1:0] rs2_data_IDEX,
    output logic [WIDTH-1:0] pc_IDEX,
    output logic [WIDTH-1:0] pc_4_IDEX,
    output logic             jump_branch_sel_IDEX,
    output logic             mem_wr_en_IDEX,
    output logic             reg_wr_en_IDEX,
    output logic [1:0]       reg_wr_ctrl_IDEX,
    output logic [4:0]       rd_IDEX,
    output logic [4:0]       rs1_IDEX,
    output logic [4:0]       rs2_IDEX,
    output logic             valid_IDEX,
    output logic             illegal_IDEX
);
    logic [6:0] op, funct7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3, imm_sel;
    logic [1:0] reg_wr_ctrl;
    logic [WIDTH-1:0] imm, rs1_data, rs2_data;
    logic in1_pc, in2_imm, jump_branch_sel, mem_wr_en, reg_wr_en, rs1_used, rs2_used, legal, lu, illegal;
    idex_t ctl, ctl_d;
    logic [WIDTH-1:0] in1_q, in2_q, imm_q, rs2_q, pc_q, pc_4_q;

    control_unit cu (
        .op(instruction_IFID[6:0]), .in1_pc(in1_pc), .in2_imm(in2_imm),
        .jump_branch_sel(jump_branch_sel), .mem_wr_en(mem_wr_en), .reg_wr_en(reg_wr_en),
        .reg_wr_ctrl(reg_wr_ctrl), .rs1_used(rs1_used), .rs2_used(rs2_used), .legal(legal),
        .imm_sel(imm_sel)
    );

    inst_splitter #(.WIDTH(WIDTH)) split (
        .instruction(instruction_IFID), .imm_sel(imm_sel), .op(op), .rd(rd), .rs1(rs1),
        .rs2(rs2), .funct3(funct3), .funct7(funct7), .immediate(imm)
    );

    register_file #(.WIDTH(WIDTH), .REG_COUNT(REG_COUNT), .BYPASS_EN(BYPASS_EN)) rf (
        .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .wr_addr(rd_WBID),
        .wr_data(reg_wr_data_WBID), .wr_en(reg_wr_en_WBID), .rs1_data(rs1_data), .rs2_data(rs2_data)
    );

    hazard_unit hz (
        .reset(reset), .flush(flush), .stall_EX(stall_EX), .valid_IFID(valid_IFID),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .rs1(rs1), .rs2(rs2),
        .valid_IDEX(ctl.valid), .reg_wr_en_IDEX(ctl.reg_wr_en), .reg_wr_ctrl_IDEX(ctl.reg_wr_ctrl),
        .rd_IDEX(ctl.rd), .lu(lu), .stall_ID(stall_ID)
    );

    // enables are suppressed for fetch holes and illegal encodings so EX/MEM never commit them
    always_comb begin
        illegal = !legal || (rs1_used && !reg_ok(rs1, REG_COUNT)) ||
                  (rs2_used && !reg_ok(rs2, REG_COUNT)) || (reg_wr_en && !reg_ok(rd, REG_COUNT));
        ctl_d = '{op: op, funct3: funct3, funct7: funct7, jump_branch_sel: jump_branch_sel,
                  mem_wr_en: mem_wr_en && valid_IFID && !illegal,
                  reg_wr_en: reg_wr_en && valid_IFID && !illegal,
                  reg_wr_ctrl: reg_wr_ctrl, rd: rd, rs1: rs1, rs2: rs2,
                  valid: valid_IFID, illegal: illegal};
    end

    always_ff @(posedge clk) begin
        if (reset || flush || (!stall_EX && lu)) begin
            ctl <= BUBBLE;
            in1_q <= '0;
            in2_q <= '0;
            imm_q <= '0;
            rs2_q <= '0;
            pc_q <= '0;
            pc_4_q <= '0;
        end else if (!stall_EX) begin
            ctl <= ctl_d;
            in1_q <= in1_pc ? pc_IFID : rs1_data;
            in2_q <= in2_imm ? imm : rs2_data;
            imm_q <= imm;
            rs2_q <= rs2_data;
            pc_q <= pc_IFID;
            pc_4_q <= pc_4_IFID;
        end
    end

    assign op_IDEX = ctl.op;
    assign funct3_IDEX = ctl.funct3;
    assign funct7_IDEX = ctl.funct7;
    assign jump_branch_sel_IDEX = ctl.jump_branch_sel;
    assign mem_wr_en_IDEX = ctl.mem_wr_en;
    assign reg_wr_en_IDEX = ctl.reg_wr_en;
    assign reg_wr_ctrl_IDEX = ctl.reg_wr_ctrl;
    assign rd_IDEX = ctl.rd;
    assign rs1_IDEX = ctl.rs1;
    assign rs2_IDEX = ctl.rs2;
    assign valid_IDEX = ctl.valid;
    assign illegal_IDEX = ctl.illegal;
    assign in1_IDEX = in1_q;
    assign in2_IDEX = in2_q;
    assign immediate_IDEX = imm_q;
    assign rs2_data_IDEX = rs2_q;
    assign pc_IDEX = pc_q;
    assign pc_4_IDEX = pc_4_q;
endmodule

// File: tb/tb_id_stage_hazard.sv
// tb_id_stage_hazard: directed checks on an RV32I/bypass instance and an RV32E/no-bypass instance
module tb_id_stage_hazard;
    logic clk = 0, reset = 1, flush = 0, stall_EX = 1, valid_IFID = 0, reg_wr_en_WBID = 0;
    logic [31:0] instruction_IFID = 0, pc_IFID = 0, pc_4_IFID = 0, reg_wr_data_WBID = 0;
    logic [4:0] rd_WBID = 0;
    logic stall_ID [2], jbs [2], mwe [2], rwe [2], valid [2], illegal [2];
    logic [6:0] op [2], funct7 [2];
    logic [2:0] funct3 [2];
    logic [1:0] rwc [2];
    logic [4:0] rd [2], rs1 [2], rs2 [2];
    logic [31:0] in1 [2], in2 [2], imm [2], rs2d [2], pc [2], pc4 [2];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : dut
        id_stage_hazard #(.WIDTH(32), .REG_COUNT(g == 0 ? 32 : 16), .BYPASS_EN(g == 0 ? 1 : 0)) u (
            .clk(clk), .reset(reset), .flush(flush), .stall_EX(stall_EX),
            .instruction_IFID(instruction_IFID), .pc_IFID(pc_IFID), .pc_4_IFID(pc_4_IFID),
            .valid_IFID(valid_IFID), .reg_wr_data_WBID(reg_wr_data_WBID), .rd_WBID(rd_WBID),
            .reg_wr_en_WBID(reg_wr_en_WBID), .stall_ID(stall_ID[g]), .op_IDEX(op[g]),
            .funct3_IDEX(funct3[g]), .funct7_IDEX(funct7[g]), .in1_IDEX(in1[g]), .in2_IDEX(in2[g]),
            .immediate_IDEX(imm[g]), .rs2_data_IDEX(rs2d[g]), .pc_IDEX(pc[g]), .pc_4_IDEX(pc4[g]),
            .jump_branch_sel_IDEX(jbs[g]), .mem_wr_en_IDEX(mwe[g]), .reg_wr_en_IDEX(rwe[g]),
            .reg_wr_ctrl_IDEX(rwc[g]), .rd_IDEX(rd[g]), .rs1_IDEX(rs1[g]), .rs2_IDEX(rs2[g]),
            .valid_IDEX(valid[g]), .illegal_IDEX(illegal[g])
        );
    end

    function automatic logic [31:0] enc_i(input logic [11:0] i, input logic [4:0] s1,
                                          input logic [2:0] f3, input logic [4:0] d, input logic [6:0] o);
        return {i, s1, f3, d, o};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] s2, input logic [4:0] s1, input logic [4:0] d);
        return {7'h00, s2, s1, 3'b000, d, 7'h33};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick;
        tick;
        for (int u = 0; u < 2; u++) begin
            chk("rst_op", 32'(op[u]), 32'h13);
            chk("rst_funct3", 32'(funct3[u]), 0);
            chk("rst_valid", 32'(valid[u]), 0);
            chk("rst_in2", in2[u], 0);
            chk("rst_rwe", 32'(rwe[u]), 0);
            chk("rst_illegal", 32'(illegal[u]), 0);
            chk("rst_stall", 32'(stall_ID[u]), 0);
        end

        reset = 0; stall_EX = 0; valid_IFID = 1; pc_IFID = 32'h100; pc_4_IFID = 32'h104;
        instruction_IFID = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'h13);
        #1 chk("addi_stall", 32'(stall_ID[0]), 0);
        tick;
        chk("addi_op", 32'(op[0]), 32'h13);
        chk("addi_in1", in1[0], 0);
        chk("addi_in2", in2[0], 5);
        chk("addi_imm", imm[0], 5);
        chk("addi_rd", 32'(rd[0]), 1);
        chk("addi_valid", 32'(valid[0]), 1);
        chk("addi_rwe", 32'(rwe[0]), 1);
        chk("addi_pc", pc[0], 32'h100);
        chk("addi_pc4", pc4[0], 32'h104);

        instruction_IFID = enc_i(12'd0, 5'd1, 3'b010, 5'd2, 7'h03);
        #1 chk("lw_nostall", 32'(stall_ID[0]), 0);
        tick;
        chk("lw_wbctrl", 32'(rwc[0]), 1);
        instruction_IFID = enc_r(5'd4, 5'd2, 5'd3);
        #1 chk("lu_stall_a", 32'(stall_ID[0]), 1);
        chk("lu_stall_b", 32'(stall_ID[1]), 1);
        tick;
        chk("lu_bubble_valid", 32'(valid[0]), 0);
        chk("lu_bubble_op", 32'(op[0]), 32'h13);
        chk("lu_bubble_rd", 32'(rd[0]), 0);
        chk("lu_release", 32'(stall_ID[0]), 0);
        tick;
        chk("dep_op", 32'(op[0]), 32'h33);
        chk("dep_rd", 32'(rd[0]), 3);
        chk("dep_valid", 32'(valid[0]), 1);

        instruction_IFID = enc_i(12'd0, 5'd1, 3'b010, 5'd2, 7'h03);
        tick;
        instruction_IFID = enc_r(5'd4, 5'd0, 5'd3);
        #1 chk("x0_dep_nostall", 32'(stall_ID[0]), 0);
        tick;
        chk("x0_dep_rd", 32'(rd[0]), 3);

        instruction_IFID = enc_i(12'd0, 5'd1, 3'b010, 5'd2, 7'h03);
        tick;
        instruction_IFID = enc_r(5'd4, 5'd2, 5'd3); valid_IFID = 0;
        #1 chk("inv_nostall", 32'(stall_ID[0]), 0);
        tick;
        chk("inv_valid", 32'(valid[0]), 0);
        chk("inv_rwe", 32'(rwe[0]), 0);
        chk("inv_rd", 32'(rd[0]), 3);

        valid_IFID = 1; instruction_IFID = enc_i(12'd0, 5'd5, 3'b000, 5'd6, 7'h13);
        reg_wr_en_WBID = 1; rd_WBID = 5; reg_wr_data_WBID = 32'hDEADBEEF;
        tick;
        chk("byp_on", in1[0], 32'hDEADBEEF);
        chk("byp_off", in1[1], 0);
        reg_wr_en_WBID = 0;
        tick;
        chk("wb_landed_a", in1[0], 32'hDEADBEEF);
        chk("wb_landed_b", in1[1], 32'hDEADBEEF);
        instruction_IFID = enc_i(12'd0, 5'd0, 3'b000, 5'd7, 7'h13);
        reg_wr_en_WBID = 1; rd_WBID = 0; reg_wr_data_WBID = 32'h1234;
        tick;
        chk("x0_byp", in1[0], 0);
        reg_wr_en_WBID = 0;
        tick;
        chk("x0_write_a", in1[0], 0);
        chk("x0_write_b", in1[1], 0);

        instruction_IFID = enc_r(5'd5, 5'd5, 5'd8); stall_EX = 1;
        #1 chk("sx_stall", 32'(stall_ID[0]), 1);
        repeat (3) begin
            tick;
            chk("sx_hold_rd", 32'(rd[0]), 7);
            chk("sx_hold_stall", 32'(stall_ID[0]), 1);
        end
        flush = 1;
        #1 chk("sx_flush_stall", 32'(stall_ID[0]), 0);
        tick;
        chk("sx_flush_valid", 32'(valid[0]), 0);
        chk("sx_flush_rd", 32'(rd[0]), 0);
        flush = 0; stall_EX = 0;
        tick;
        chk("sx_resume_rd", 32'(rd[0]), 8);
        chk("sx_resume_in1", in1[0], 32'hDEADBEEF);
        chk("sx_resume_rs2", rs2d[0], 32'hDEADBEEF);

        instruction_IFID = enc_i(12'd0, 5'd5, 3'b010, 5'd9, 7'h03);
        tick;
        instruction_IFID = enc_r(5'd9, 5'd9, 5'd10); stall_EX = 1;
        #1 chk("lu_sx_stall", 32'(stall_ID[0]), 1);
        tick;
        chk("lu_sx_hold", 32'(rd[0]), 9);
        stall_EX = 0;
        #1 chk("lu_after_sx", 32'(stall_ID[0]), 1);
        flush = 1;
        #1 chk("lu_flush_stall", 32'(stall_ID[0]), 0);
        tick;
        chk("lu_flush_valid", 32'(valid[0]), 0);
        chk("lu_flush_rd", 32'(rd[0]), 0);
        flush = 0; instruction_IFID = enc_i(12'd1, 5'd0, 3'b000, 5'd11, 7'h13);
        tick;
        chk("post_flush_rd", 32'(rd[0]), 11);

        instruction_IFID = enc_r(5'd2, 5'd1, 5'd17);
        tick;
        chk("rv32e_illegal", 32'(illegal[1]), 1);
        chk("rv32e_rwe", 32'(rwe[1]), 0);
        chk("rv32i_legal", 32'(illegal[0]), 0);
        chk("rv32i_rwe", 32'(rwe[0]), 1);
        instruction_IFID = 32'h0000007F;
        tick;
        chk("badop_a", 32'(illegal[0]), 1);
        chk("badop_b", 32'(illegal[1]), 1);
        chk("badop_rwe", 32'(rwe[0]), 0);
        instruction_IFID = {7'h7F, 5'd5, 5'd0, 3'b010, 5'h1C, 7'h23};
        tick;
        chk("sw_imm", imm[0], 32'hFFFFFFFC);
        chk("sw_in2", in2[0], 32'hFFFFFFFC);
        chk("sw_mwe", 32'(mwe[0]), 1);
        chk("sw_rwe", 32'(rwe[0]), 0);
        chk("sw_rs2", rs2d[0], 32'hDEADBEEF);
        chk("sw_illegal", 32'(illegal[0]), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
